// File: rtl/fifo_axi_burst_writer_if.sv
`default_nettype none
// ============================================================================
// Module   : fifo_axi_burst_writer_if
// Purpose  : FIFO read port plus AXI4 write-channel bundle for the burst writer.
// Revision : 1.0  initial release
// ============================================================================
interface fifo_axi_burst_writer_if #(
    parameter int FIFO_WIDTH     = 8,
    parameter int AXI_DATA_WIDTH = 32,
    parameter int ADDR_WIDTH     = 32
) ();
    logic                          fifo_empty;
    logic [FIFO_WIDTH-1:0]         fifo_rdata;
    logic                          fifo_r_en;

    logic [ADDR_WIDTH-1:0]         m_awaddr;
    logic [7:0]                    m_awlen;
    logic [2:0]                    m_awsize;
    logic [1:0]                    m_awburst;
    logic                          m_awvalid;
    logic                          m_awready;

    logic [AXI_DATA_WIDTH-1:0]     m_wdata;
    logic [AXI_DATA_WIDTH/8-1:0]   m_wstrb;
    logic                          m_wlast;
    logic                          m_wvalid;
    logic                          m_wready;

    logic [1:0]                    m_bresp;
    logic                          m_bvalid;
    logic                          m_bready;

    modport master (
        input  fifo_empty, fifo_rdata,
        output fifo_r_en,
        output m_awaddr, m_awlen, m_awsize, m_awburst, m_awvalid,
        input  m_awready,
        output m_wdata, m_wstrb, m_wlast, m_wvalid,
        input  m_wready,
        input  m_bresp, m_bvalid,
        output m_bready
    );

    modport slave (
        output fifo_empty, fifo_rdata,
        input  fifo_r_en,
        input  m_awaddr, m_awlen, m_awsize, m_awburst, m_awvalid,
        output m_awready,
        input  m_wdata, m_wstrb, m_wlast, m_wvalid,
        output m_wready,
        output m_bresp, m_bvalid,
        input  m_bready
    );
endinterface
`default_nettype wire

// File: rtl/fifo_axi_burst_writer.sv
`default_nettype none
// ============================================================================
// Module   : fifo_axi_burst_writer
// Purpose  : Packs FIFO bytes into 32-bit beats and writes them to a circular
//            DDR region as AXI4 INCR bursts. Optional macro
//            AXI_WR_BURST_CNT_EN adds a 16-bit completed-burst counter.
// Revision : 1.0  initial release
// ============================================================================
module fifo_axi_burst_writer #(
    parameter int                    FIFO_WIDTH     = 8,
    parameter int                    AXI_DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH     = 32,
    parameter int                    BURST_LEN      = 4,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = '0,
    parameter int                    REGION_BYTES   = 4096
) (
    input  wire logic                rclk,
    input  wire logic                rrst_n,
    fifo_axi_burst_writer_if.master  bus,
    output logic                     busy,
    output logic                     resp_err
`ifdef AXI_WR_BURST_CNT_EN
    ,
    output logic [15:0]              burst_cnt
`endif
);

    localparam int TOTAL = 4 * BURST_LEN;
    localparam int IW    = $clog2(TOTAL);
    localparam int CW    = $clog2(TOTAL + 1);
    localparam int BW    = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int LANES = AXI_DATA_WIDTH / FIFO_WIDTH;

    localparam logic [CW-1:0]         TOTAL_C     = CW'(TOTAL);
    localparam logic [BW-1:0]         LAST_BEAT   = BW'(BURST_LEN - 1);
    localparam logic [ADDR_WIDTH-1:0] BURST_BYTES = ADDR_WIDTH'(BURST_LEN * 4);
    localparam logic [ADDR_WIDTH-1:0] REGION_END  = BASE_ADDR + ADDR_WIDTH'(REGION_BYTES);

    typedef enum logic [1:0] {
        S_FILL = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [CW-1:0]           req_q, req_d;
    logic [CW-1:0]           rcv_q, rcv_d;
    logic                    pend_q, pend_d;
    logic [BW-1:0]           beat_q, beat_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic                    err_q, err_d;
    logic [FIFO_WIDTH-1:0]   buf_q [TOTAL];
    logic [FIFO_WIDTH-1:0]   buf_d [TOTAL];
`ifdef AXI_WR_BURST_CNT_EN
    logic [15:0]             cnt_q, cnt_d;
`endif

    logic                    pop;
    logic [ADDR_WIDTH-1:0]   addr_next;
    logic [IW-1:0]           rd_base;

    // Reset also gates the pop so the FIFO is left untouched while rrst_n is low.
    assign pop       = rrst_n && (state_q == S_FILL) && !bus.fifo_empty && (req_q < TOTAL_C);
    assign addr_next = addr_q + BURST_BYTES;

    always_comb begin
        state_d       = state_q;
        req_d         = req_q;
        rcv_d         = rcv_q;
        pend_d        = 1'b0;
        beat_d        = beat_q;
        addr_d        = addr_q;
        err_d         = err_q;
        buf_d         = buf_q;
`ifdef AXI_WR_BURST_CNT_EN
        cnt_d         = cnt_q;
`endif
        bus.m_awvalid = 1'b0;
        bus.m_wvalid  = 1'b0;
        bus.m_bready  = 1'b0;

        case (state_q)
            S_FILL: begin
                pend_d = pop;
                if (pop) begin
                    req_d = req_q + 1'b1;
                end
                // fifo_rdata belongs to the pop issued on the previous cycle.
                if (pend_q) begin
                    buf_d[rcv_q[IW-1:0]] = bus.fifo_rdata;
                    rcv_d                = rcv_q + 1'b1;
                    if (rcv_q == TOTAL_C - 1'b1) begin
                        state_d = S_ADDR;
                    end
                end
            end
            S_ADDR: begin
                bus.m_awvalid = 1'b1;
                if (bus.m_awready) begin
                    beat_d  = '0;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                bus.m_wvalid = 1'b1;
                if (bus.m_wready) begin
                    if (beat_q == LAST_BEAT) begin
                        state_d = S_RESP;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            S_RESP: begin
                bus.m_bready = 1'b1;
                if (bus.m_bvalid) begin
                    if (bus.m_bresp != 2'b00) begin
                        err_d = 1'b1;
                    end
                    addr_d  = (addr_next == REGION_END) ? BASE_ADDR : addr_next;
                    req_d   = '0;
                    rcv_d   = '0;
                    beat_d  = '0;
`ifdef AXI_WR_BURST_CNT_EN
                    cnt_d   = cnt_q + 16'd1;
`endif
                    state_d = S_FILL;
                end
            end
            default: begin
                state_d = S_FILL;
            end
        endcase
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            state_q <= S_FILL;
            req_q   <= '0;
            rcv_q   <= '0;
            pend_q  <= 1'b0;
            beat_q  <= '0;
            addr_q  <= BASE_ADDR;
            err_q   <= 1'b0;
            buf_q   <= '{default: '0};
`ifdef AXI_WR_BURST_CNT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            rcv_q   <= rcv_d;
            pend_q  <= pend_d;
            beat_q  <= beat_d;
            addr_q  <= addr_d;
            err_q   <= err_d;
            buf_q   <= buf_d;
`ifdef AXI_WR_BURST_CNT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    // Byte 4*beat lands in lane 0, giving little-endian packing.
    assign rd_base = IW'({beat_q, 2'b00});

    always_comb begin
        bus.m_wdata = '0;
        for (int l = 0; l < LANES; l++) begin
            bus.m_wdata[l*FIFO_WIDTH +: FIFO_WIDTH] = buf_q[rd_base + IW'(l)];
        end
    end

    assign bus.fifo_r_en = pop;
    assign bus.m_awaddr  = addr_q;
    assign bus.m_awlen   = 8'(BURST_LEN - 1);
    assign bus.m_awsize  = 3'b010;
    assign bus.m_awburst = 2'b01;
    assign bus.m_wstrb   = '1;
    assign bus.m_wlast   = (state_q == S_DATA) && (beat_q == LAST_BEAT);

    assign busy      = (state_q != S_FILL) || (rcv_q != '0);
    assign resp_err  = err_q;
`ifdef AXI_WR_BURST_CNT_EN
    assign burst_cnt = cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_axi_burst_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_axi_burst_writer
// Purpose  : Directed self-checking bench for fifo_axi_burst_writer.
// Revision : 1.0  initial release
// ============================================================================
module tb_fifo_axi_burst_writer;

    logic rclk   = 1'b0;
    logic rrst_n = 1'b0;
    always #5 rclk = ~rclk;

    fifo_axi_burst_writer_if #(.FIFO_WIDTH(8), .AXI_DATA_WIDTH(32), .ADDR_WIDTH(32)) bus_if ();

    logic busy;
    logic resp_err;
`ifdef AXI_WR_BURST_CNT_EN
    logic [15:0] burst_cnt;
`endif

    fifo_axi_burst_writer dut (
        .rclk     (rclk),
        .rrst_n   (rrst_n),
        .bus      (bus_if.master),
        .busy     (busy),
        .resp_err (resp_err)
`ifdef AXI_WR_BURST_CNT_EN
        ,
        .burst_cnt(burst_cnt)
`endif
    );

    // FIFO model: data_out is registered, valid the cycle after a pop
    logic [7:0] mem [0:8191];
    int wr_ptr   = 0;
    int rd_ptr   = 0;
    int byte_val = 0;
    assign bus_if.fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge rclk) begin
        if (bus_if.fifo_r_en && (wr_ptr != rd_ptr)) begin
            bus_if.fifo_rdata <= mem[rd_ptr];
            rd_ptr            <= rd_ptr + 1;
        end
    end

    // Bus monitor
    logic [31:0] aw_log [$];
    logic [31:0] w_log  [$];
    logic        wl_log [$];
    int          b_cnt    = 0;
    int          early_w  = 0;
    int          unstable = 0;
    bit          aw_done, aw_stall, w_stall;
    logic [31:0] aw_prev, w_prev;

    always @(posedge rclk) begin
        if (!rrst_n) begin
            aw_done  = 1'b0;
            aw_stall = 1'b0;
            w_stall  = 1'b0;
        end else begin
            if (aw_stall && (!bus_if.m_awvalid || bus_if.m_awaddr !== aw_prev)) unstable++;
            if (w_stall  && (!bus_if.m_wvalid  || bus_if.m_wdata  !== w_prev))  unstable++;
            aw_stall = bus_if.m_awvalid && !bus_if.m_awready;
            w_stall  = bus_if.m_wvalid  && !bus_if.m_wready;
            aw_prev  = bus_if.m_awaddr;
            w_prev   = bus_if.m_wdata;
            if (bus_if.m_awvalid && bus_if.m_awready) begin
                aw_log.push_back(bus_if.m_awaddr);
                aw_done = 1'b1;
            end
            if (bus_if.m_wvalid && !aw_done) early_w++;
            if (bus_if.m_wvalid && bus_if.m_wready) begin
                w_log.push_back(bus_if.m_wdata);
                wl_log.push_back(bus_if.m_wlast);
                if (bus_if.m_wlast) aw_done = 1'b0;
            end
            if (bus_if.m_bvalid && bus_if.m_bready) b_cnt++;
        end
    end

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic push(input int n);
        for (int i = 0; i < n; i++) begin
            mem[wr_ptr] = 8'(byte_val);
            wr_ptr++;
            byte_val++;
        end
    endtask

    task automatic wait_b(input int target, input int budget);
        int c;
        c = 0;
        while (b_cnt < target && c < budget) begin
            @(posedge rclk);
            c++;
        end
        @(negedge rclk);
        chk("b_handshake_count", 32'(b_cnt), 32'(target));
    endtask

    initial begin
        int aw_n, w_n, c;
        bus_if.m_awready = 1'b1;
        bus_if.m_wready  = 1'b1;
        bus_if.m_bvalid  = 1'b1;
        bus_if.m_bresp   = 2'b00;

        // Reset state
        repeat (3) @(negedge rclk);
        chk("rst_awvalid", 32'(bus_if.m_awvalid), 0);
        chk("rst_wvalid",  32'(bus_if.m_wvalid), 0);
        chk("rst_bready",  32'(bus_if.m_bready), 0);
        chk("rst_r_en",    32'(bus_if.fifo_r_en), 0);
        chk("rst_awaddr",  bus_if.m_awaddr, 32'h0);
        chk("rst_resp_err", 32'(resp_err), 0);
        chk("rst_busy",    32'(busy), 0);
        chk("awlen",       32'(bus_if.m_awlen), 3);
        chk("awsize",      32'(bus_if.m_awsize), 2);
        chk("awburst",     32'(bus_if.m_awburst), 1);
        chk("wstrb",       32'(bus_if.m_wstrb), 32'hF);
        rrst_n = 1'b1;
        @(negedge rclk);

        // One burst of bytes 0x00..0x0F, ready always high
        push(16);
        wait_b(1, 100);
        chk("t1_aw_count", 32'(aw_log.size()), 1);
        chk("t1_awaddr", aw_log[0], 32'h0);
        chk("t1_beat0", w_log[0], 32'h03020100);
        chk("t1_beat1", w_log[1], 32'h07060504);
        chk("t1_beat2", w_log[2], 32'h0B0A0908);
        chk("t1_beat3", w_log[3], 32'h0F0E0D0C);
        chk("t1_wlast", {28'h0, wl_log[3], wl_log[2], wl_log[1], wl_log[0]}, 32'h8);
        chk("t1_resp_err", 32'(resp_err), 0);
        chk("t1_busy_idle", 32'(busy), 0);

        // 15 bytes: must stay in FILL; 16th byte starts the burst
        bus_if.m_awready = 1'b0;
        bus_if.m_wready  = 1'b0;
        push(15);
        repeat (25) @(negedge rclk);
        chk("t2_no_aw", 32'(bus_if.m_awvalid), 0);
        chk("t2_busy_partial", 32'(busy), 1);
        push(1);
        @(posedge rclk);
        @(posedge rclk);
        @(negedge rclk);
        chk("t2_awvalid_2cyc", 32'(bus_if.m_awvalid), 1);
        chk("t2_awaddr", bus_if.m_awaddr, 32'h10);
        repeat (5) @(negedge rclk);
        bus_if.m_awready = 1'b1;
        @(negedge rclk);
        bus_if.m_awready = 1'b0;
        for (int i = 0; i < 12; i++) begin
            bus_if.m_wready = i[0];
            @(negedge rclk);
        end
        bus_if.m_awready = 1'b1;
        bus_if.m_wready  = 1'b1;
        wait_b(2, 50);
        chk("t2_w_count", 32'(w_log.size()), 8);
        chk("t2_awaddr_log", aw_log[1], 32'h10);
        chk("t2_beat0", w_log[4], 32'h13121110);
        chk("t2_beat3", w_log[7], 32'h1F1E1D1C);
        chk("t2_stable", 32'(unstable), 0);
        chk("t2_no_early_w", 32'(early_w), 0);

        // Error response is sticky
        bus_if.m_bresp = 2'b10;
        push(16);
        wait_b(3, 100);
        bus_if.m_bresp = 2'b00;
        chk("t3_awaddr", aw_log[2], 32'h20);
        chk("t3_resp_err", 32'(resp_err), 1);

        // Fill the whole 4 KB region, then one more burst wraps to base
        push(254 * 16);
        wait_b(257, 254 * 40);
        chk("t4_aw256", aw_log[255], 32'hFF0);
        chk("t4_aw257", aw_log[256], 32'h000);
        chk("t4_b256_beat0", w_log[1020], 32'hF3F2F1F0);
        chk("t4_b257_beat0", w_log[1024], 32'h03020100);
        chk("t4_resp_err_sticky", 32'(resp_err), 1);

        // Reset during the second beat of a burst
        bus_if.m_wready = 1'b0;
        push(16);
        c = 0;
        while (!bus_if.m_wvalid && c < 100) begin
            @(negedge rclk);
            c++;
        end
        chk("t5_wvalid_seen", 32'(bus_if.m_wvalid), 1);
        chk("t5_awaddr", aw_log[257], 32'h10);
        bus_if.m_wready = 1'b1;
        @(negedge rclk);
        bus_if.m_wready = 1'b0;
        chk("t5_beat2_data", bus_if.m_wdata, 32'h17161514);
        rrst_n = 1'b0;
        #1;
        chk("t5_rst_awvalid", 32'(bus_if.m_awvalid), 0);
        chk("t5_rst_wvalid",  32'(bus_if.m_wvalid), 0);
        chk("t5_rst_wlast",   32'(bus_if.m_wlast), 0);
        chk("t5_rst_bready",  32'(bus_if.m_bready), 0);
        chk("t5_rst_resp_err", 32'(resp_err), 0);
        chk("t5_rst_awaddr",  bus_if.m_awaddr, 32'h0);
        chk("t5_rst_busy",    32'(busy), 0);
        repeat (2) @(negedge rclk);
        rrst_n          = 1'b1;
        bus_if.m_wready = 1'b1;
        aw_n = aw_log.size();
        w_n  = w_log.size();
        @(negedge rclk);
        push(16);
        wait_b(258, 100);
        chk("t5_new_awaddr", aw_log[aw_n], 32'h0);
        chk("t5_new_beat0", w_log[w_n], 32'h23222120);
        chk("t5_new_beat3", w_log[w_n + 3], 32'h2F2E2D2C);
        chk("t5_resp_err_clear", 32'(resp_err), 0);
        chk("t5_no_early_w", 32'(early_w), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
